// File: rtl/digit_wr_arbiter_pkg.sv
// Shared definitions for the 7-segment display write arbiter: FSM encoding,
// default display address and the byte-lane merge used to widen masked writes.
package digit_wr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [11:0] DIGIT_ADDR_DEFAULT = 12'h000;
    localparam int          ADDR_W             = 12;
    localparam int          DATA_W             = 32;
    localparam int          BE_W               = 4;

    // Per byte lane: take the new byte where enabled, otherwise keep the old one.
    function automatic logic [31:0] merge(input logic [31:0] old_word,
                                          input logic [31:0] new_word,
                                          input logic [3:0]  be);
        logic [31:0] result;
        result = old_word;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                result[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/digit_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first valid requester scanning
// upward from rr_ptr with wrap-around. Reusable for any shared I/O port.
module digit_wr_arbiter_rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IW-1:0]   rr_ptr,
    output logic [IW-1:0]   grant_idx,
    output logic            any_req
);

    logic [IW-1:0]   cand_idx [NREQ];
    logic [NREQ-1:0] cand_valid;

    // Candidate at scan offset gi is (rr_ptr + gi) mod NREQ.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [IW:0] sum;
            logic [IW:0] wrapped;
            assign sum            = {1'b0, rr_ptr} + (IW+1)'(gi);
            assign wrapped        = sum - (IW+1)'(NREQ);
            assign cand_idx[gi]   = (sum >= (IW+1)'(NREQ)) ? wrapped[IW-1:0] : sum[IW-1:0];
            assign cand_valid[gi] = req_valid[cand_idx[gi]];
        end
    endgenerate

    // Walk offsets from farthest to nearest so the smallest offset wins.
    always_comb begin
        grant_idx = '0;
        any_req   = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (cand_valid[i]) begin
                grant_idx = cand_idx[i];
                any_req   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/digit_wr_arbiter.sv
// Round-robin arbiter for the display peripheral's write port. Grants one
// requester at a time, merges byte-masked writes with a shadow of the
// displayed word and presents full-word writes to the peripheral.
module digit_wr_arbiter
    import digit_wr_arbiter_pkg::*;
#(
    parameter int          NREQ       = 2,
    parameter logic [11:0] DIGIT_ADDR = DIGIT_ADDR_DEFAULT,
    parameter int          GAP        = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [12*NREQ-1:0]   req_addr,
    input  logic [32*NREQ-1:0]   req_wdata,
    input  logic [4*NREQ-1:0]    req_be,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      req_err,
    output logic [11:0]          dig_addr,
    output logic                 dig_wen,
    output logic [31:0]          dig_wdata,
    output logic [31:0]          shadow,
    output logic                 busy
);

    localparam int            IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0]    HOLD_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);

    state_t             state_q, state_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]      gnt_q, gnt_d;
    logic [3:0]         hold_cnt_q, hold_cnt_d;
    logic [31:0]        shadow_q, shadow_d;
    logic [NREQ-1:0]    req_ready_q, req_ready_d;
    logic [NREQ-1:0]    req_err_q, req_err_d;
    logic               dig_wen_q, dig_wen_d;
    logic [11:0]        dig_addr_q, dig_addr_d;
    logic [31:0]        dig_wdata_q, dig_wdata_d;

    logic [IW-1:0]      pick_idx;
    logic               any_req;
    logic [11:0]        win_addr;
    logic [31:0]        win_wdata;
    logic [3:0]         win_be;

    digit_wr_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant_idx (pick_idx),
        .any_req   (any_req)
    );

    assign win_addr  = req_addr [ADDR_W*pick_idx +: ADDR_W];
    assign win_wdata = req_wdata[DATA_W*pick_idx +: DATA_W];
    assign win_be    = req_be   [BE_W*pick_idx   +: BE_W];

    // Next-state logic: the write outputs are computed at grant time so they
    // appear registered during the single WRITE cycle.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        hold_cnt_d  = hold_cnt_q;
        shadow_d    = shadow_q;
        req_ready_d = '0;
        req_err_d   = '0;
        dig_wen_d   = 1'b0;
        dig_addr_d  = dig_addr_q;
        dig_wdata_d = dig_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_d                 = pick_idx;
                    req_ready_d[pick_idx] = 1'b1;
                    state_d               = ST_WRITE;
                    if (win_addr == DIGIT_ADDR) begin
                        dig_wen_d   = 1'b1;
                        dig_addr_d  = win_addr;
                        dig_wdata_d = merge(shadow_q, win_wdata, win_be);
                    end else begin
                        req_err_d[pick_idx] = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (dig_wen_q) begin
                    shadow_d = dig_wdata_q;
                end
                rr_ptr_d = (gnt_q == LAST_IDX) ? '0 : gnt_q + 1'b1;
                if (GAP > 0) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; asynchronous reset aborts any write at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            hold_cnt_q  <= '0;
            shadow_q    <= '0;
            req_ready_q <= '0;
            req_err_q   <= '0;
            dig_wen_q   <= 1'b0;
            dig_addr_q  <= '0;
            dig_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            hold_cnt_q  <= hold_cnt_d;
            shadow_q    <= shadow_d;
            req_ready_q <= req_ready_d;
            req_err_q   <= req_err_d;
            dig_wen_q   <= dig_wen_d;
            dig_addr_q  <= dig_addr_d;
            dig_wdata_q <= dig_wdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign req_err   = req_err_q;
    assign dig_wen   = dig_wen_q;
    assign dig_addr  = dig_addr_q;
    assign dig_wdata = dig_wdata_q;
    assign shadow    = shadow_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_digit_wr_arbiter.sv
// Bench for digit_wr_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level model of the arbitration rules.
module tb_digit_wr_arbiter;

    localparam int          NREQ  = 2;
    localparam logic [11:0] DADDR = 12'h000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // GAP=0 instance
    logic [NREQ-1:0]    req_valid;
    logic [12*NREQ-1:0] req_addr;
    logic [32*NREQ-1:0] req_wdata;
    logic [4*NREQ-1:0]  req_be;
    logic [NREQ-1:0]    req_ready, req_err;
    logic [11:0]        dig_addr;
    logic               dig_wen;
    logic [31:0]        dig_wdata, shadow;
    logic               busy;

    // GAP=3 instance
    logic [NREQ-1:0]    g3_valid;
    logic [12*NREQ-1:0] g3_addr;
    logic [32*NREQ-1:0] g3_wdata;
    logic [4*NREQ-1:0]  g3_be;
    logic [NREQ-1:0]    g3_ready, g3_err;
    logic [11:0]        g3_dig_addr;
    logic               g3_wen;
    logic [31:0]        g3_dig_wdata, g3_shadow;
    logic               g3_busy;

    int checks = 0;
    int passed = 0;

    digit_wr_arbiter #(.NREQ(NREQ), .DIGIT_ADDR(DADDR), .GAP(0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .req_ready(req_ready), .req_err(req_err),
        .dig_addr(dig_addr), .dig_wen(dig_wen), .dig_wdata(dig_wdata),
        .shadow(shadow), .busy(busy)
    );

    digit_wr_arbiter #(.NREQ(NREQ), .DIGIT_ADDR(DADDR), .GAP(3)) dut_g3 (
        .clk(clk), .rst(rst),
        .req_valid(g3_valid), .req_addr(g3_addr), .req_wdata(g3_wdata), .req_be(g3_be),
        .req_ready(g3_ready), .req_err(g3_err),
        .dig_addr(g3_dig_addr), .dig_wen(g3_wen), .dig_wdata(g3_dig_wdata),
        .shadow(g3_shadow), .busy(g3_busy)
    );

    task automatic clear_reqs();
        req_valid = '0; req_addr = '0; req_wdata = '0; req_be = '0;
        g3_valid  = '0; g3_addr  = '0; g3_wdata  = '0; g3_be  = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic [11:0] a,
                           input logic [31:0] d, input logic [3:0] b);
        req_valid[i]        = v;
        req_addr[12*i +: 12] = a;
        req_wdata[32*i +: 32] = d;
        req_be[4*i +: 4]     = b;
    endtask

    task automatic do_reset();
        clear_reqs();
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_reqs();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({shadow, dig_wen, req_ready, req_err, busy, dig_addr, dig_wdata} !== '0 ||
            {g3_shadow, g3_wen, g3_ready, g3_busy} !== '0) begin
            $display("FAIL reset_values: shadow=%h wen=%b ready=%b err=%b busy=%b addr=%h wdata=%h, required all zero",
                     shadow, dig_wen, req_ready, req_err, busy, dig_addr, dig_wdata);
        end else passed++;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (shadow !== 32'h0 || dig_wen !== 1'b0 || req_ready !== 2'b00 || busy !== 1'b0) begin
                $display("FAIL reset_idle cyc%0d: shadow=%h wen=%b ready=%b busy=%b, required 0/0/00/0",
                         c, shadow, dig_wen, req_ready, busy);
            end else passed++;
        end
    endtask

    task automatic test_full_write();
        @(negedge clk);
        set_req(0, 1'b1, DADDR, 32'h12345678, 4'hF);
        @(posedge clk); #1;
        // Change the payload and drop valid after the grant edge: must not matter.
        set_req(0, 1'b0, 12'hFFF, 32'hDEADBEEF, 4'h0);
        @(negedge clk);
        $display("txn full_write req0 be=F -> wen=%b wdata=%h ready=%b", dig_wen, dig_wdata, req_ready);
        checks++;
        if ({dig_wen, req_ready, req_err, busy} !== {1'b1, 2'b01, 2'b00, 1'b1}) begin
            $display("FAIL full_write_ctrl: wen/ready/err/busy=%b/%b/%b/%b, required 1/01/00/1",
                     dig_wen, req_ready, req_err, busy);
        end else passed++;
        checks++;
        if (dig_wdata !== 32'h12345678 || dig_addr !== DADDR || shadow !== 32'h0) begin
            $display("FAIL full_write_data: wdata=%h addr=%h shadow=%h, required 12345678/%h/00000000",
                     dig_wdata, dig_addr, shadow, DADDR);
        end else passed++;
        @(negedge clk);
        checks++;
        if (shadow !== 32'h12345678 || dig_wen !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b00) begin
            $display("FAIL full_write_after: shadow=%h wen=%b busy=%b ready=%b, required 12345678/0/0/00",
                     shadow, dig_wen, busy, req_ready);
        end else passed++;
    endtask

    task automatic test_masked_write();
        set_req(1, 1'b1, DADDR, 32'hAABBCCDD, 4'b0101);
        @(negedge clk);
        $display("txn masked_write req1 be=5 -> wen=%b wdata=%h ready=%b", dig_wen, dig_wdata, req_ready);
        set_req(1, 1'b0, DADDR, 32'h0, 4'h0);
        checks++;
        if (dig_wen !== 1'b1 || dig_wdata !== 32'h12BB56DD || req_ready !== 2'b10) begin
            $display("FAIL masked_write: wen=%b wdata=%h ready=%b, required 1/12BB56DD/10",
                     dig_wen, dig_wdata, req_ready);
        end else passed++;
        @(negedge clk);
        checks++;
        if (shadow !== 32'h12BB56DD) begin
            $display("FAIL masked_shadow: shadow=%h, required 12BB56DD", shadow);
        end else passed++;
    endtask

    task automatic test_addr_miss();
        set_req(0, 1'b1, 12'h004, 32'hFFFFFFFF, 4'hF);
        @(negedge clk);
        $display("txn addr_miss req0 addr=004 -> ready=%b err=%b wen=%b", req_ready, req_err, dig_wen);
        set_req(0, 1'b0, 12'h0, 32'h0, 4'h0);
        checks++;
        if ({req_ready, req_err, dig_wen} !== {2'b01, 2'b01, 1'b0}) begin
            $display("FAIL addr_miss_ctrl: ready/err/wen=%b/%b/%b, required 01/01/0", req_ready, req_err, dig_wen);
        end else passed++;
        checks++;
        if (dig_addr !== DADDR || dig_wdata !== 32'h12BB56DD) begin
            $display("FAIL addr_miss_hold: addr=%h wdata=%h, required %h/12BB56DD", dig_addr, dig_wdata, DADDR);
        end else passed++;
        @(negedge clk);
        checks++;
        if (shadow !== 32'h12BB56DD || req_err !== 2'b00) begin
            $display("FAIL addr_miss_shadow: shadow=%h err=%b, required 12BB56DD/00", shadow, req_err);
        end else passed++;
    endtask

    task automatic test_be_zero();
        set_req(1, 1'b1, DADDR, 32'h55555555, 4'h0);
        @(negedge clk);
        $display("txn be_zero req1 -> wen=%b wdata=%h", dig_wen, dig_wdata);
        set_req(1, 1'b0, DADDR, 32'h0, 4'h0);
        checks++;
        if (dig_wen !== 1'b1 || dig_wdata !== 32'h12BB56DD || req_ready !== 2'b10 || req_err !== 2'b00) begin
            $display("FAIL be_zero: wen=%b wdata=%h ready=%b err=%b, required 1/12BB56DD/10/00",
                     dig_wen, dig_wdata, req_ready, req_err);
        end else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        set_req(0, 1'b1, DADDR, 32'hCAFEF00D, 4'hF);
        @(posedge clk); #2;
        checks++;
        if (dig_wen !== 1'b1) begin
            $display("FAIL midrst_pre: wen=%b, required 1", dig_wen);
        end else passed++;
        rst = 1'b1;
        #1;
        checks++;
        if ({dig_wen, req_ready, req_err, busy, shadow, dig_wdata} !== '0) begin
            $display("FAIL midrst_abort: wen=%b ready=%b busy=%b shadow=%h wdata=%h, required all zero",
                     dig_wen, req_ready, busy, shadow, dig_wdata);
        end else passed++;
        clear_reqs();
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || shadow !== 32'h0 || dig_wen !== 1'b0) begin
            $display("FAIL midrst_after: busy=%b shadow=%h wen=%b, required 0/0/0", busy, shadow, dig_wen);
        end else passed++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ready;
        logic [31:0] exp_data;
        do_reset();
        set_req(0, 1'b1, DADDR, 32'h000000A0, 4'hF);
        set_req(1, 1'b1, DADDR, 32'h000000B1, 4'hF);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            exp_ready = (c % 2 == 0) ? 2'b00 : ((c % 4 == 1) ? 2'b01 : 2'b10);
            exp_data  = (c % 4 == 1) ? 32'h000000A0 : 32'h000000B1;
            if (c % 2 == 1) $display("txn rr cyc%0d ready=%b wdata=%h", c, req_ready, dig_wdata);
            checks++;
            if ({req_ready, dig_wen, busy} !== {exp_ready, exp_ready != 2'b00, exp_ready != 2'b00} ||
                (exp_ready != 2'b00 && dig_wdata !== exp_data)) begin
                $display("FAIL rr_gap0 cyc%0d: ready=%b wen=%b busy=%b wdata=%h, required ready=%b wdata=%h",
                         c, req_ready, dig_wen, busy, dig_wdata, exp_ready, exp_data);
            end else passed++;
        end
        clear_reqs();
        @(negedge clk);
    endtask

    task automatic test_gap();
        logic [1:0] exp_ready;
        do_reset();
        g3_valid = 2'b11;
        g3_addr  = {DADDR, DADDR};
        g3_wdata = {32'h11110001, 32'h22220000};
        g3_be    = 8'hFF;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            exp_ready = (c % 5 != 1) ? 2'b00 : ((((c - 1) / 5) % 2 == 0) ? 2'b01 : 2'b10);
            if (g3_wen) $display("txn gap3 cyc%0d ready=%b wdata=%h", c, g3_ready, g3_dig_wdata);
            checks++;
            if ({g3_ready, g3_wen, g3_busy} !== {exp_ready, exp_ready != 2'b00, (c % 5) != 0}) begin
                $display("FAIL rr_gap3 cyc%0d: ready=%b wen=%b busy=%b, required ready=%b busy=%b",
                         c, g3_ready, g3_wen, g3_busy, exp_ready, (c % 5) != 0);
            end else passed++;
        end
        clear_reqs();
        @(negedge clk);
    endtask

    // Transaction-level model state for the randomized run.
    int          m_ptr, m_rem, w;
    logic [1:0]  e_ready, e_err;
    logic        e_wen, e_busy;
    logic [11:0] e_addr;
    logic [31:0] e_wdata, e_shadow, d;
    logic [3:0]  b;

    task automatic test_random();
        do_reset();
        m_ptr = 0; m_rem = 0;
        e_ready = '0; e_err = '0; e_wen = 1'b0; e_busy = 1'b0;
        e_addr = '0; e_wdata = '0; e_shadow = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            checks++;
            if ({req_ready, req_err, dig_wen, busy} !== {e_ready, e_err, e_wen, e_busy}) begin
                $display("FAIL rand_ctrl cyc%0d: ready=%b err=%b wen=%b busy=%b, required %b/%b/%b/%b",
                         cyc, req_ready, req_err, dig_wen, busy, e_ready, e_err, e_wen, e_busy);
            end else passed++;
            checks++;
            if (shadow !== e_shadow || dig_addr !== e_addr || dig_wdata !== e_wdata) begin
                $display("FAIL rand_data cyc%0d: shadow=%h addr=%h wdata=%h, required %h/%h/%h",
                         cyc, shadow, dig_addr, dig_wdata, e_shadow, e_addr, e_wdata);
            end else passed++;
            if (e_ready != 2'b00) $display("txn rand cyc%0d ready=%b err=%b wdata=%h", cyc, e_ready, e_err, e_wdata);

            // Requesters: hold until served, then renew or drop; idle ones may start.
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || e_ready[i]) begin
                    if ($urandom_range(0, 99) < 45)
                        set_req(i, 1'b1,
                                ($urandom_range(0, 3) != 0) ? DADDR : 12'($urandom_range(1, 4095)),
                                $urandom, 4'($urandom));
                    else
                        req_valid[i] = 1'b0;
                end
            end

            // Model the effect of the coming clock edge.
            if (e_wen) e_shadow = e_wdata;
            e_ready = '0; e_err = '0; e_wen = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
            end else if (req_valid != '0) begin
                w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                end
                e_ready[w] = 1'b1;
                d = req_wdata[32*w +: 32];
                b = req_be[4*w +: 4];
                if (req_addr[12*w +: 12] == DADDR) begin
                    e_wen  = 1'b1;
                    e_addr = req_addr[12*w +: 12];
                    for (int k = 0; k < 4; k++) e_wdata[8*k +: 8] = b[k] ? d[8*k +: 8] : e_shadow[8*k +: 8];
                end else begin
                    e_err[w] = 1'b1;
                end
                m_ptr = (w + 1) % NREQ;
                m_rem = 1;
            end
            e_busy = (m_rem > 0);
        end
        clear_reqs();
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_masked_write();
        test_addr_miss();
        test_be_zero();
        test_reset_mid_write();
        test_round_robin();
        test_gap();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

endmodule
